conv_line_buffer: RTL and testbench

- Upstream feeder of the 5x5 convolution stage in the HDMI filter path.
- Takes a raster pixel stream (one pixel per clock with dv/hs/vs) and keeps the last 4 lines in cascaded line RAMs.
- Presents a 5-pixel vertical column (rows n-4..n) per clock, with dv/hs/vs delayed to stay aligned with the column.
- Also reports which rows hold valid data and flags lines longer than the buffers.

---
 rtl/conv_pkg.sv | 12 +
 rtl/line_ram.sv | 20 ++
 rtl/conv_line_buffer.sv | 96 +++++++++
 tb/tb_conv_line_buffer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and the line-end pulse for the 5x5 convolution path.
package conv_pkg;
    localparam int COLORDEPTH  = 8;
    localparam int SCREENWIDTH = 1600;
    localparam int M_DEPTH     = 5;
    localparam int AW          = 11;

    // A line ends on the first cycle after dv drops.
    function automatic logic line_end(input logic dv_prev, input logic dv_cur);
        return dv_prev & ~dv_cur;
    endfunction
endpackage

// File: rtl/line_ram.sv
// line_ram: simple dual-port, read-first, synchronous-read line memory.
module line_ram #(
    parameter int DW    = 8,
    parameter int AW    = 11,
    parameter int DEPTH = 1600
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: keeps the last 4 lines in cascaded line RAMs and emits a
// 5-pixel vertical column per clock, sync-aligned, with row validity masking.
module conv_line_buffer #(
    parameter int COLORDEPTH  = conv_pkg::COLORDEPTH,
    parameter int SCREENWIDTH = conv_pkg::SCREENWIDTH,
    parameter int M_DEPTH     = conv_pkg::M_DEPTH,
    parameter int AW          = conv_pkg::AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] px_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] vect_o_0,
    output logic [COLORDEPTH-1:0] vect_o_1,
    output logic [COLORDEPTH-1:0] vect_o_2,
    output logic [COLORDEPTH-1:0] vect_o_3,
    output logic [COLORDEPTH-1:0] vect_o_4,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [2:0]            rows_valid_o,
    output logic                  ovf_o
);
    import conv_pkg::*;

    localparam int NR = M_DEPTH - 1;
    localparam logic [AW-1:0] LAST = AW'(SCREENWIDTH - 1);

    logic [AW-1:0]         wr_addr, addr_d;
    logic [COLORDEPTH-1:0] px_d;
    logic [COLORDEPTH-1:0] rd   [NR];
    logic [COLORDEPTH-1:0] vect [M_DEPTH];
    logic                  dv_d, hs_d, vs_d, full, fall;
    logic [2:0]            line_cnt, cnt_d;

    assign fall = line_end(dv_d, dv_i);

    // Each RAM hands its old contents one line further down the cascade.
    for (genvar k = 0; k < NR; k++) begin : g_ram
        if (k == 0) begin : g_head
            line_ram #(.DW(COLORDEPTH), .AW(AW), .DEPTH(SCREENWIDTH)) u_ram (
                .clk(clk), .we(dv_i), .wa(wr_addr), .wd(px_i), .ra(wr_addr), .rd(rd[k])
            );
        end else begin : g_tail
            line_ram #(.DW(COLORDEPTH), .AW(AW), .DEPTH(SCREENWIDTH)) u_ram (
                .clk(clk), .we(dv_d), .wa(addr_d), .wd(rd[k-1]), .ra(wr_addr), .rd(rd[k])
            );
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr      <= '0;
            addr_d       <= '0;
            full         <= 1'b0;
            ovf_o        <= 1'b0;
            line_cnt     <= '0;
            cnt_d        <= '0;
            px_d         <= '0;
            dv_d         <= 1'b0;
            hs_d         <= 1'b0;
            vs_d         <= 1'b0;
            dv_o         <= 1'b0;
            hs_o         <= 1'b0;
            vs_o         <= 1'b0;
            rows_valid_o <= '0;
            for (int k = 0; k < M_DEPTH; k++) vect[k] <= '0;
        end else begin
            wr_addr  <= !dv_i ? '0 : (wr_addr == LAST) ? wr_addr : wr_addr + 1'b1;
            // full marks that the last address has been written; a further pixel overflows.
            full     <= dv_i && (full || wr_addr == LAST);
            ovf_o    <= vs_i ? 1'b0 : (ovf_o || (dv_i && full));
            line_cnt <= vs_i ? '0 : (fall && line_cnt < 3'd4) ? line_cnt + 1'b1 : line_cnt;
            addr_d   <= wr_addr;
            cnt_d    <= line_cnt;
            px_d     <= px_i;
            dv_d     <= dv_i;
            hs_d     <= hs_i;
            vs_d     <= vs_i;
            dv_o     <= dv_d;
            hs_o     <= hs_d;
            vs_o     <= vs_d;
            rows_valid_o <= cnt_d;
            vect[0]  <= dv_d ? px_d : '0;
            for (int k = 1; k < M_DEPTH; k++) vect[k] <= (dv_d && 3'(k) <= cnt_d) ? rd[k-1] : '0;
        end
    end

    assign vect_o_0 = vect[0];
    assign vect_o_1 = vect[1];
    assign vect_o_2 = vect[2];
    assign vect_o_3 = vect[3];
    assign vect_o_4 = vect[4];
endmodule

// File: tb/tb_conv_line_buffer.sv
// tb_conv_line_buffer: directed column vectors plus sync, overflow and reset sequences.
module tb_conv_line_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] px_i = '0;
    logic       dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [7:0] vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4;
    logic       dv_o, hs_o, vs_o, ovf_o;
    logic [2:0] rows_valid_o;

    int pass_cnt = 0, total = 0;
    int tl = -1, tc = -1, tl1 = -1, tc1 = -1, tl2 = -1, tc2 = -1;
    logic [2:0] h1, h2;

    typedef struct {
        int              line;
        int              col;
        logic [0:4][7:0] v;
        logic [2:0]      rv;
    } vec_t;
    localparam int NV = 13;
    vec_t tbl [NV];
    bit   seen [NV];

    conv_line_buffer #(.COLORDEPTH(8), .SCREENWIDTH(8), .M_DEPTH(5), .AW(3)) dut (
        .clk(clk), .rst(rst), .px_i(px_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .vect_o_0(vect_o_0), .vect_o_1(vect_o_1), .vect_o_2(vect_o_2),
        .vect_o_3(vect_o_3), .vect_o_4(vect_o_4),
        .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .rows_valid_o(rows_valid_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Inputs and their line/col tags travel two cycles to meet the outputs.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            h1 <= '0; h2 <= '0; tl1 <= -1; tc1 <= -1; tl2 <= -1; tc2 <= -1;
        end else begin
            h1 <= {dv_i, hs_i, vs_i}; h2 <= h1;
            tl1 <= tl; tc1 <= tc; tl2 <= tl1; tc2 <= tc1;
        end
    end

    always @(negedge clk) begin
        chk("sync_delay", {dv_o, hs_o, vs_o}, h2);
        for (int i = 0; i < NV; i++)
            if (h2[2] && tl2 == tbl[i].line && tc2 == tbl[i].col) begin
                seen[i] = 1'b1;
                chk($sformatf("v0_l%0d_c%0d", tbl[i].line, tbl[i].col), vect_o_0, tbl[i].v[0]);
                chk($sformatf("v1_l%0d_c%0d", tbl[i].line, tbl[i].col), vect_o_1, tbl[i].v[1]);
                chk($sformatf("v2_l%0d_c%0d", tbl[i].line, tbl[i].col), vect_o_2, tbl[i].v[2]);
                chk($sformatf("v3_l%0d_c%0d", tbl[i].line, tbl[i].col), vect_o_3, tbl[i].v[3]);
                chk($sformatf("v4_l%0d_c%0d", tbl[i].line, tbl[i].col), vect_o_4, tbl[i].v[4]);
                chk($sformatf("rv_l%0d_c%0d", tbl[i].line, tbl[i].col), rows_valid_o, tbl[i].rv);
            end
    end

    task automatic drive(input logic [7:0] p, input logic d, h, v, input int l, c);
        px_i = p; dv_i = d; hs_i = h; vs_i = v; tl = l; tc = c;
        @(posedge clk); #1;
    endtask

    task automatic blank(input logic vs_at_end);
        drive(8'h00, 1'b0, 1'b0, vs_at_end, -1, -1);
        drive(8'h00, 1'b0, 1'b1, 1'b0, -1, -1);
        drive(8'h00, 1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic line(input int l, input int n, input logic vs_at_end);
        for (int c = 0; c < n; c++) drive(8'(16 * l + c), 1'b1, 1'b0, 1'b0, l, c);
        blank(vs_at_end);
    endtask

    task automatic vs_pulse();
        drive(8'h00, 1'b0, 1'b0, 1'b1, -1, -1);
        drive(8'h00, 1'b0, 1'b0, 1'b1, -1, -1);
        drive(8'h00, 1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_vect"}, {vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4}, 40'h0);
        chk({name, "_flags"}, {dv_o, hs_o, vs_o, ovf_o, rows_valid_o}, 7'h0);
    endtask

    initial begin
        tbl[0]  = '{0,  5, {8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 3'd0};
        tbl[1]  = '{1,  7, {8'h17, 8'h07, 8'h00, 8'h00, 8'h00}, 3'd1};
        tbl[2]  = '{2,  7, {8'h27, 8'h17, 8'h07, 8'h00, 8'h00}, 3'd2};
        tbl[3]  = '{3,  6, {8'h36, 8'h26, 8'h16, 8'h06, 8'h00}, 3'd3};
        tbl[4]  = '{4,  6, {8'h46, 8'h36, 8'h26, 8'h16, 8'h06}, 3'd4};
        tbl[5]  = '{5,  3, {8'h53, 8'h43, 8'h33, 8'h23, 8'h13}, 3'd4};
        tbl[6]  = '{6,  2, {8'h62, 8'h00, 8'h00, 8'h00, 8'h00}, 3'd0};
        tbl[7]  = '{7,  4, {8'h74, 8'h64, 8'h00, 8'h00, 8'h00}, 3'd1};
        tbl[8]  = '{9,  1, {8'h91, 8'h00, 8'h00, 8'h00, 8'h00}, 3'd0};
        tbl[9]  = '{11, 0, {8'hB0, 8'hA0, 8'h00, 8'h00, 8'h00}, 3'd1};
        tbl[10] = '{11, 7, {8'hB7, 8'hA9, 8'h00, 8'h00, 8'h00}, 3'd1};
        tbl[11] = '{15, 1, {8'hF1, 8'hE1, 8'hD1, 8'hC1, 8'h00}, 3'd3};
        tbl[12] = '{16, 5, {8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 3'd0};
        for (int i = 0; i < NV; i++) seen[i] = 1'b0;

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst = 1'b1;

        // Ramp frame, then a mid-frame vs, then a line end coinciding with vs.
        vs_pulse();
        for (int l = 0; l < 6; l++) line(l, 8, 1'b0);
        vs_pulse();
        line(6, 8, 1'b0);
        line(7, 8, 1'b0);
        line(8, 8, 1'b1);
        line(9, 8, 1'b0);

        // Overflow: 10 pixels into an 8-entry line.
        vs_pulse();
        chk("ovf_clear_start", ovf_o, 1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(8'(16 * 10 + c), 1'b1, 1'b0, 1'b0, 10, c);
            if (c == 7) chk("ovf_after_px8", ovf_o, 1'b0);
            if (c == 8) chk("ovf_after_px9", ovf_o, 1'b1);
        end
        blank(1'b0);
        chk("ovf_sticky", ovf_o, 1'b1);
        line(11, 8, 1'b0);
        chk("ovf_sticky_next_line", ovf_o, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b1, -1, -1);
        chk("ovf_vs_clear", ovf_o, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, -1, -1);

        // Asynchronous reset partway through the fourth line of a frame.
        line(12, 8, 1'b0);
        line(13, 8, 1'b0);
        line(14, 8, 1'b0);
        for (int c = 0; c < 4; c++) drive(8'(16 * 15 + c), 1'b1, 1'b0, 1'b0, 15, c);
        chk("pre_reset_dv", dv_o, 1'b1);
        #1 rst = 1'b0;
        #1 chk_all_zero("async_reset");
        dv_i = 1'b0; px_i = '0; tl = -1; tc = -1;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset_hold");
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0, -1, -1);
        line(16, 8, 1'b0);

        // Random sync patterns; the sync delay check runs every cycle.
        for (int i = 0; i < 40; i++)
            drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1, -1);
        repeat (3) drive(8'h00, 1'b0, 1'b0, 1'b0, -1, -1);

        for (int i = 0; i < NV; i++)
            if (!seen[i]) begin
                total++;
                $display("FAIL vec_seen: line %0d col %0d never observed (got 0 expected 1)", tbl[i].line, tbl[i].col);
            end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
